// File: rtl/polibot_pkg.sv
// Shared definitions for the move sequencer: move codes, FSM state encoding
// and servo position values.
package polibot_pkg;

    localparam logic [2:0] MOV_NOP        = 3'd0;
    localparam logic [2:0] MOV_BASE_MAIS  = 3'd1;
    localparam logic [2:0] MOV_BASE_MENOS = 3'd2;
    localparam logic [2:0] MOV_BASE_180   = 3'd3;
    localparam logic [2:0] MOV_PETELECO   = 3'd4;
    localparam logic [2:0] MOV_FACE_MAIS  = 3'd5;
    localparam logic [2:0] MOV_FACE_MENOS = 3'd6;
    localparam logic [2:0] MOV_FACE_180   = 3'd7;

    localparam logic [1:0] BASE_0   = 2'd0;
    localparam logic [1:0] BASE_90  = 2'd1;
    localparam logic [1:0] BASE_180 = 2'd2;

    localparam logic TAMPA_ABERTA       = 1'b0;
    localparam logic TAMPA_FECHADA      = 1'b1;
    localparam logic PETELECO_RECOLHIDO = 1'b0;
    localparam logic PETELECO_EMPURRA   = 1'b1;

    typedef enum logic [3:0] {
        Ocioso     = 4'd0,
        Decodifica = 4'd1,
        FechaTampa = 4'd2,
        GiraBase   = 4'd3,
        AbreTampa  = 4'd4,
        Empurra    = 4'd5,
        Recolhe    = 4'd6,
        Espera     = 4'd7,
        Fim        = 4'd8,
        Erro       = 4'd9
    } estado_e;

    function automatic logic eh_face(input logic [2:0] codigo);
        return codigo[2] && (codigo != MOV_PETELECO);
    endfunction

    function automatic logic eh_180(input logic [2:0] codigo);
        return codigo[1:0] == 2'b11;
    endfunction

    function automatic logic movimento_legal(input logic [2:0] codigo, input logic [1:0] base);
        case (codigo)
            MOV_BASE_MAIS, MOV_FACE_MAIS:   return base < BASE_180;
            MOV_BASE_MENOS, MOV_FACE_MENOS: return base > BASE_0;
            MOV_BASE_180, MOV_FACE_180:     return base != BASE_90;
            default:                        return 1'b1;
        endcase
    endfunction

    // Only called after the legality check, so the result never wraps.
    function automatic logic [1:0] base_destino(input logic [2:0] codigo, input logic [1:0] base);
        case (codigo)
            MOV_BASE_MAIS, MOV_FACE_MAIS:   return base + 2'd1;
            MOV_BASE_MENOS, MOV_FACE_MENOS: return base - 2'd1;
            default:                        return BASE_180 - base;
        endcase
    endfunction

endpackage

// File: rtl/contador_espera.sv
// Load/decrement down-counter used for servo settling delays; saturates at zero.
module contador_espera #(
    parameter int unsigned W_CONT = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              carrega,
    input  logic [W_CONT-1:0] valor,
    output logic              zero
);

    logic [W_CONT-1:0] cont_d, cont_q;

    always_comb begin
        cont_d = cont_q;
        if (carrega) begin
            cont_d = valor;
        end else if (cont_q != '0) begin
            cont_d = cont_q - W_CONT'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign zero = (cont_q == '0);

endmodule

// File: rtl/sequenciador_movimento.sv
// Turns one cube-move code into timed base/tampa/peteleco servo positions,
// with a start pulse in and a one-cycle completion pulse out.
module sequenciador_movimento
    import polibot_pkg::*;
#(
    parameter int unsigned T_SERVO    = 25_000_000,
    parameter int unsigned T_PETELECO = 15_000_000,
    parameter int unsigned W_CONT     = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar_mov,
    input  logic [2:0] codigo_mov,
    output logic [1:0] posicao_base,
    output logic       posicao_tampa,
    output logic       posicao_peteleco,
    output logic       ocupado,
    output logic       fim_movimento,
    output logic       erro,
    output logic [3:0] db_estado
);

    // Counter is loaded with D-1: the ESPERA state then lasts exactly D cycles.
    localparam logic [W_CONT-1:0] CARGA_SERVO     = W_CONT'(T_SERVO - 1);
    localparam logic [W_CONT-1:0] CARGA_SERVO_180 = W_CONT'(2 * T_SERVO - 1);
    localparam logic [W_CONT-1:0] CARGA_PETELECO  = W_CONT'(T_PETELECO - 1);

    estado_e     estado_d, estado_q;
    estado_e     proximo_d, proximo_q;
    logic [2:0]  codigo_d, codigo_q;
    logic [1:0]  base_d, base_q;
    logic        tampa_d, tampa_q;
    logic        peteleco_d, peteleco_q;
    logic        ocupado_d, ocupado_q;
    logic        fim_d, fim_q;
    logic        erro_d, erro_q;

    logic              carrega;
    logic [W_CONT-1:0] valor;
    logic              zero;

    contador_espera #(
        .W_CONT (W_CONT)
    ) u_contador (
        .clock   (clock),
        .reset   (reset),
        .carrega (carrega),
        .valor   (valor),
        .zero    (zero)
    );

    always_comb begin
        estado_d   = estado_q;
        proximo_d  = proximo_q;
        codigo_d   = codigo_q;
        base_d     = base_q;
        tampa_d    = tampa_q;
        peteleco_d = peteleco_q;
        ocupado_d  = ocupado_q;
        fim_d      = 1'b0;
        erro_d     = 1'b0;
        carrega    = 1'b0;
        valor      = '0;

        unique case (estado_q)
            Ocioso: begin
                if (iniciar_mov) begin
                    codigo_d = codigo_mov;
                    estado_d = Decodifica;
                end
            end
            Decodifica: begin
                ocupado_d = 1'b1;
                if (codigo_q == MOV_NOP) begin
                    estado_d = Fim;
                end else if (!movimento_legal(codigo_q, base_q)) begin
                    estado_d = Erro;
                end else if (eh_face(codigo_q)) begin
                    estado_d = FechaTampa;
                end else if (codigo_q == MOV_PETELECO) begin
                    estado_d = Empurra;
                end else begin
                    estado_d = GiraBase;
                end
            end
            FechaTampa: begin
                tampa_d   = TAMPA_FECHADA;
                carrega   = 1'b1;
                valor     = CARGA_SERVO;
                proximo_d = GiraBase;
                estado_d  = Espera;
            end
            GiraBase: begin
                base_d    = base_destino(codigo_q, base_q);
                carrega   = 1'b1;
                valor     = eh_180(codigo_q) ? CARGA_SERVO_180 : CARGA_SERVO;
                proximo_d = eh_face(codigo_q) ? AbreTampa : Fim;
                estado_d  = Espera;
            end
            AbreTampa: begin
                tampa_d   = TAMPA_ABERTA;
                carrega   = 1'b1;
                valor     = CARGA_SERVO;
                proximo_d = Fim;
                estado_d  = Espera;
            end
            Empurra: begin
                peteleco_d = PETELECO_EMPURRA;
                carrega    = 1'b1;
                valor      = CARGA_PETELECO;
                proximo_d  = Recolhe;
                estado_d   = Espera;
            end
            Recolhe: begin
                peteleco_d = PETELECO_RECOLHIDO;
                carrega    = 1'b1;
                valor      = CARGA_PETELECO;
                proximo_d  = Fim;
                estado_d   = Espera;
            end
            Espera: begin
                if (zero) begin
                    estado_d = proximo_q;
                end
            end
            Fim: begin
                fim_d     = 1'b1;
                ocupado_d = 1'b0;
                estado_d  = Ocioso;
            end
            Erro: begin
                fim_d     = 1'b1;
                erro_d    = 1'b1;
                ocupado_d = 1'b0;
                estado_d  = Ocioso;
            end
            default: begin
                estado_d = Ocioso;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= Ocioso;
            proximo_q  <= Ocioso;
            codigo_q   <= MOV_NOP;
            base_q     <= BASE_90;
            tampa_q    <= TAMPA_ABERTA;
            peteleco_q <= PETELECO_RECOLHIDO;
            ocupado_q  <= 1'b0;
            fim_q      <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            proximo_q  <= proximo_d;
            codigo_q   <= codigo_d;
            base_q     <= base_d;
            tampa_q    <= tampa_d;
            peteleco_q <= peteleco_d;
            ocupado_q  <= ocupado_d;
            fim_q      <= fim_d;
            erro_q     <= erro_d;
        end
    end

    assign posicao_base     = base_q;
    assign posicao_tampa    = tampa_q;
    assign posicao_peteleco = peteleco_q;
    assign ocupado          = ocupado_q;
    assign fim_movimento    = fim_q;
    assign erro             = erro_q;
    assign db_estado        = estado_q;

endmodule

// File: tb/tb_sequenciador_movimento.sv
// Bench for sequenciador_movimento: directed and random moves checked cycle by
// cycle against a timing model derived from the move rules.
module tb_sequenciador_movimento;

    localparam int unsigned TS = 4;
    localparam int unsigned TP = 3;
    localparam int NUNCA = 100000;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar_mov;
    logic [2:0] codigo_mov;
    logic [1:0] posicao_base;
    logic       posicao_tampa;
    logic       posicao_peteleco;
    logic       ocupado;
    logic       fim_movimento;
    logic       erro;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;
    int base_m = 1;

    always #5 clock = ~clock;

    sequenciador_movimento #(
        .T_SERVO    (TS),
        .T_PETELECO (TP),
        .W_CONT     (26)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .iniciar_mov      (iniciar_mov),
        .codigo_mov       (codigo_mov),
        .posicao_base     (posicao_base),
        .posicao_tampa    (posicao_tampa),
        .posicao_peteleco (posicao_peteleco),
        .ocupado          (ocupado),
        .fim_movimento    (fim_movimento),
        .erro             (erro),
        .db_estado        (db_estado)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected timeline: each output changes at a fixed cycle after acceptance (cycle 0).
    task automatic run_move(input int code, input bit noise, input int abort_k);
        int  nb, d, nk;
        int  t_base, t_close, t_open, t_push, t_ret, t_fim;
        bit  ilegal;
        ilegal  = 1'b0;
        nb      = base_m;
        t_base  = NUNCA;
        t_close = NUNCA;
        t_open  = NUNCA;
        t_push  = NUNCA;
        t_ret   = NUNCA;
        d       = (code == 3 || code == 7) ? 2 * TS : TS;
        if (code == 1 || code == 5) begin
            ilegal = (base_m >= 2);
            nb     = base_m + 1;
        end else if (code == 2 || code == 6) begin
            ilegal = (base_m <= 0);
            nb     = base_m - 1;
        end else if (code == 3 || code == 7) begin
            ilegal = (base_m == 1);
            nb     = 2 - base_m;
        end
        if (code == 0 || ilegal) begin
            nb    = base_m;
            t_fim = 2;
        end else if (code <= 3) begin
            t_base = 2;
            t_fim  = 3 + d;
        end else if (code == 4) begin
            t_push = 2;
            t_ret  = 3 + TP;
            t_fim  = 4 + 2 * TP;
        end else begin
            t_close = 2;
            t_base  = 3 + TS;
            t_open  = 4 + TS + d;
            t_fim   = 5 + 2 * TS + d;
        end
        nk = (t_fim > 6) ? 4 : 1;

        codigo_mov  = 3'(code);
        iniciar_mov = 1'b1;
        for (int k = 0; k <= t_fim; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k == 0 || k == nk + 1) iniciar_mov = 1'b0;
            check($sformatf("base c%0d k%0d", code, k), 4'(posicao_base),
                  4'((k >= t_base) ? nb : base_m));
            check($sformatf("tampa c%0d k%0d", code, k), 4'(posicao_tampa),
                  4'(k >= t_close && k < t_open));
            check($sformatf("peteleco c%0d k%0d", code, k), 4'(posicao_peteleco),
                  4'(k >= t_push && k < t_ret));
            check($sformatf("ocupado c%0d k%0d", code, k), 4'(ocupado),
                  4'(k >= 1 && k < t_fim));
            check($sformatf("fim c%0d k%0d", code, k), 4'(fim_movimento), 4'(k == t_fim));
            check($sformatf("erro c%0d k%0d", code, k), 4'(erro), 4'(ilegal && k == t_fim));
            if (k == t_fim) check($sformatf("estado c%0d fim", code), db_estado, 4'd0);
            if (k == abort_k) break;
            if (noise && k == nk) begin
                iniciar_mov = 1'b1;
                codigo_mov  = 3'($urandom_range(0, 7));
            end
        end
        if (abort_k < 0) base_m = nb;
    endtask

    initial begin
        reset       = 1'b1;
        iniciar_mov = 1'b0;
        codigo_mov  = 3'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst base", 4'(posicao_base), 4'd1);
        check("rst tampa", 4'(posicao_tampa), 4'd0);
        check("rst peteleco", 4'(posicao_peteleco), 4'd0);
        check("rst ocupado", 4'(ocupado), 4'd0);
        check("rst fim", 4'(fim_movimento), 4'd0);
        check("rst erro", 4'(erro), 4'd0);
        check("rst estado", db_estado, 4'd0);
        reset  = 1'b0;
        base_m = 1;

        run_move(1, 1'b0, -1);  // base 1 -> 2
        run_move(7, 1'b0, -1);  // face 180, 2 -> 0
        run_move(4, 1'b0, -1);  // flip
        run_move(1, 1'b0, -1);  // 0 -> 1
        run_move(3, 1'b0, -1);  // illegal from 1
        run_move(2, 1'b0, -1);  // 1 -> 0
        run_move(2, 1'b0, -1);  // illegal from 0
        run_move(0, 1'b0, -1);  // NOP
        run_move(5, 1'b1, -1);  // face +90 with an ignored request mid-move
        run_move(3, 1'b1, -1);  // back-to-back, 180 from 1 is illegal

        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            run_move(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1);
        end

        // Reset in the middle of a face turn, with the lid closed.
        run_move((base_m == 2) ? 6 : 5, 1'b0, 3);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midrst tampa", 4'(posicao_tampa), 4'd0);
        check("midrst base", 4'(posicao_base), 4'd1);
        check("midrst estado", db_estado, 4'd0);
        check("midrst fim", 4'(fim_movimento), 4'd0);
        check("midrst ocupado", 4'(ocupado), 4'd0);
        reset  = 1'b0;
        base_m = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            check($sformatf("posrst fim k%0d", k), 4'(fim_movimento), 4'd0);
            check($sformatf("posrst estado k%0d", k), db_estado, 4'd0);
        end
        run_move(2, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
